// File: rtl/datapath_pkg.sv
// Shared constants and ALU function codes for the datapath slice.
// Shifter functions exist only when DATAPATH_SHIFT_EN is defined.
package datapath_pkg;

  localparam int unsigned DW        = 64;
  localparam int unsigned NREG      = 32;
  localparam int unsigned REG_AW    = 5;
  localparam int unsigned RAM_DEPTH = 256;
  localparam int unsigned RAM_AW    = 8;
  localparam int unsigned SHW       = 6;

  localparam logic [REG_AW-1:0] ZERO_REG = 5'd31;

  // Bit positions within STAT = {V,C,N,Z}
  localparam int unsigned STAT_Z = 0;
  localparam int unsigned STAT_N = 1;
  localparam int unsigned STAT_C = 2;
  localparam int unsigned STAT_V = 3;

  typedef enum logic [2:0] {
    FN_AND   = 3'b000,
    FN_OR    = 3'b001,
    FN_ADD   = 3'b010,
    FN_XOR   = 3'b011,
    FN_SHL   = 3'b100,
    FN_SHR   = 3'b101,
    FN_ZERO0 = 3'b110,
    FN_ZERO1 = 3'b111
  } alu_fn_e;

endpackage

// File: rtl/datapath_alu.sv
// Combinational ALU with optional operand inversion and {V,C,N,Z} status.
// Shifts are built only when DATAPATH_SHIFT_EN is defined.
module datapath_alu
  import datapath_pkg::*;
(
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  input  logic [4:0]    fs_i,
  input  logic          c0_i,
  output logic [DW-1:0] result_o,
  output logic [3:0]    stat_o
);

  logic [DW-1:0] a_op;
  logic [DW-1:0] b_op;
  logic [DW:0]   sum;
  logic          c_flag;
  logic          v_flag;
  alu_fn_e       fn;

  assign a_op = fs_i[1] ? ~a_i : a_i;
  assign b_op = fs_i[0] ? ~b_i : b_i;
  assign sum  = {1'b0, a_op} + {1'b0, b_op} + (DW+1)'(c0_i);
  assign fn   = alu_fn_e'(fs_i[4:2]);

  always_comb begin
    result_o = '0;
    c_flag   = 1'b0;
    v_flag   = 1'b0;
    case (fn)
      FN_AND: result_o = a_op & b_op;
      FN_OR:  result_o = a_op | b_op;
      FN_XOR: result_o = a_op ^ b_op;
      FN_ADD: begin
        result_o = sum[DW-1:0];
        c_flag   = sum[DW];
        // Like-signed operands producing an opposite-signed sum
        v_flag   = (a_op[DW-1] == b_op[DW-1]) && (sum[DW-1] != a_op[DW-1]);
      end
`ifdef DATAPATH_SHIFT_EN
      FN_SHL: result_o = a_op << b_op[SHW-1:0];
      FN_SHR: result_o = a_op >> b_op[SHW-1:0];
`endif
      default: result_o = '0;
    endcase
  end

  always_comb begin
    stat_o         = '0;
    stat_o[STAT_Z] = (result_o == '0);
    stat_o[STAT_N] = result_o[DW-1];
    stat_o[STAT_C] = c_flag;
    stat_o[STAT_V] = v_flag;
  end

endmodule

// File: rtl/datapath.sv
// Register file, RAM and data-bus mux around datapath_alu.
// Build option: DATAPATH_SHIFT_EN enables the ALU shift functions.
module datapath
  import datapath_pkg::*;
(
  input  logic          CLK,
  input  logic          RST,
  input  logic [4:0]    SA,
  input  logic [4:0]    SB,
  input  logic [4:0]    DA,
  input  logic          WR,
  input  logic [4:0]    FS,
  input  logic          C0,
  input  logic [63:0]   K,
  input  logic          M,
  input  logic          EN_ALU,
  input  logic          EN_B,
  input  logic          EN_ADDR_ALU,
  input  logic          RCS,
  input  logic          RWE,
  input  logic          ROE,
  output logic [3:0]    STAT,
  output logic [15:0]   r0,
  output logic [15:0]   r1,
  output logic [15:0]   r2,
  output logic [15:0]   r3,
  output logic [15:0]   r4,
  output logic [15:0]   r5,
  output logic [15:0]   r6,
  output logic [15:0]   r7
);

  logic [DW-1:0]     regs_q [NREG];
  logic [DW-1:0]     mem_q  [RAM_DEPTH];
  logic [DW-1:0]     a_rd;
  logic [DW-1:0]     b_rd;
  logic [DW-1:0]     b_op;
  logic [DW-1:0]     alu_res;
  logic [DW-1:0]     data_bus;
  logic [RAM_AW-1:0] ram_addr;
  logic              ram_rd_en;

  assign a_rd = (SA == ZERO_REG) ? '0 : regs_q[SA];
  assign b_rd = (SB == ZERO_REG) ? '0 : regs_q[SB];
  assign b_op = M ? b_rd : K;

  datapath_alu u_alu (
    .a_i      (a_rd),
    .b_i      (b_op),
    .fs_i     (FS),
    .c0_i     (C0),
    .result_o (alu_res),
    .stat_o   (STAT)
  );

  assign ram_addr  = EN_ADDR_ALU ? alu_res[RAM_AW-1:0] : '0;
  assign ram_rd_en = RCS && ROE && !RWE;

  always_comb begin
    data_bus = '0;
    if (ram_rd_en)   data_bus = mem_q[ram_addr];
    else if (EN_ALU) data_bus = alu_res;
    else if (EN_B)   data_bus = b_rd;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int unsigned i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (WR && (DA != ZERO_REG)) begin
      regs_q[DA] <= data_bus;
    end
  end

  // RAM has no reset; RST only blocks writes while asserted
  always_ff @(posedge CLK) begin
    if (RST && RCS && RWE) mem_q[ram_addr] <= data_bus;
  end

  assign r0 = regs_q[0][15:0];
  assign r1 = regs_q[1][15:0];
  assign r2 = regs_q[2][15:0];
  assign r3 = regs_q[3][15:0];
  assign r4 = regs_q[4][15:0];
  assign r5 = regs_q[5][15:0];
  assign r6 = regs_q[6][15:0];
  assign r7 = regs_q[7][15:0];

endmodule

// File: tb/tb_datapath.sv
// Scoreboard bench for datapath: expectations queued at drive time, popped at check time.
module tb_datapath;

  logic        CLK = 1'b0;
  logic        RST;
  logic [4:0]  SA, SB, DA, FS;
  logic        WR, C0, M, EN_ALU, EN_B, EN_ADDR_ALU, RCS, RWE, ROE;
  logic [63:0] K;
  logic [3:0]  STAT;
  logic [15:0] r0, r1, r2, r3, r4, r5, r6, r7;
  logic [15:0] rv [8];

  int vectors = 0;
  int miscompares = 0;

  logic [63:0] exp_q [$];
  logic [63:0] mreg [32];
  logic [63:0] mram [256];

  always #5 CLK = ~CLK;

  datapath dut (
    .CLK(CLK), .RST(RST), .SA(SA), .SB(SB), .DA(DA), .WR(WR), .FS(FS), .C0(C0),
    .K(K), .M(M), .EN_ALU(EN_ALU), .EN_B(EN_B), .EN_ADDR_ALU(EN_ADDR_ALU),
    .RCS(RCS), .RWE(RWE), .ROE(ROE), .STAT(STAT),
    .r0(r0), .r1(r1), .r2(r2), .r3(r3), .r4(r4), .r5(r5), .r6(r6), .r7(r7)
  );

  assign rv[0] = r0; assign rv[1] = r1; assign rv[2] = r2; assign rv[3] = r3;
  assign rv[4] = r4; assign rv[5] = r5; assign rv[6] = r6; assign rv[7] = r7;

  function automatic logic [67:0] alu_model(input logic [63:0] a, input logic [63:0] b,
                                             input logic [4:0] fs, input logic c0);
    logic [63:0] ao, bo, r;
    logic [64:0] s65;
    logic [65:0] sx;
    logic        c, v;
    ao = fs[1] ? ~a : a;
    bo = fs[0] ? ~b : b;
    r = 64'd0; c = 1'b0; v = 1'b0;
    case (fs[4:2])
      3'b000: r = ao & bo;
      3'b001: r = ao | bo;
      3'b011: r = ao ^ bo;
      3'b010: begin
        s65 = {1'b0, ao} + {1'b0, bo} + {64'd0, c0};
        r   = s65[63:0];
        c   = s65[64];
        sx  = {{2{ao[63]}}, ao} + {{2{bo[63]}}, bo} + {65'd0, c0};
        v   = !((sx[65:63] == 3'b000) || (sx[65:63] == 3'b111));
      end
`ifdef DATAPATH_SHIFT_EN
      3'b100: r = ao << bo[5:0];
      3'b101: r = ao >> bo[5:0];
`endif
      default: r = 64'd0;
    endcase
    return {v, c, r[63], (r == 64'd0), r};
  endfunction

  task automatic eval(output logic [63:0] res, output logic [3:0] st,
                      output logic [63:0] bus, output logic [7:0] addr);
    logic [63:0] a, breg;
    a    = (SA == 5'd31) ? 64'd0 : mreg[SA];
    breg = (SB == 5'd31) ? 64'd0 : mreg[SB];
    {st, res} = alu_model(a, M ? breg : K, FS, C0);
    addr = EN_ADDR_ALU ? res[7:0] : 8'd0;
    if (RCS && ROE && !RWE) bus = mram[addr];
    else if (EN_ALU)        bus = res;
    else if (EN_B)          bus = breg;
    else                    bus = 64'd0;
  endtask

  task automatic tick();
    logic [63:0] res, bus;
    logic [3:0]  st;
    logic [7:0]  addr;
    eval(res, st, bus, addr);
    @(posedge CLK);
    if (RST) begin
      if (RCS && RWE) mram[addr] = bus;
      if (WR && DA != 5'd31) mreg[DA] = bus;
    end
    #1;
  endtask

  task automatic idle_inputs();
    SA = 5'd0; SB = 5'd0; DA = 5'd0; FS = 5'd0; WR = 1'b0; C0 = 1'b0; M = 1'b0;
    K = 64'd0; EN_ALU = 1'b0; EN_B = 1'b0; EN_ADDR_ALU = 1'b0;
    RCS = 1'b0; RWE = 1'b0; ROE = 1'b0;
  endtask

  task automatic test_reset();
    logic [63:0] e;
    for (int i = 0; i < 8; i++) exp_q.push_back(64'd0);
    exp_q.push_back(64'h1);
    #1;
    for (int i = 0; i < 8; i++) begin
      e = exp_q.pop_front(); vectors++;
      if (rv[i] !== e[15:0]) begin
        miscompares++; $display("FAIL reset_r%0d got %h expected %h", i, rv[i], e[15:0]);
      end
    end
    e = exp_q.pop_front(); vectors++;
    if (STAT !== e[3:0]) begin
      miscompares++; $display("FAIL reset_stat got %b expected %b", STAT, e[3:0]);
    end
    // write attempted while held in reset must be ignored
    SA = 5'd30; SB = 5'd30; FS = 5'b01000; EN_ALU = 1'b1; WR = 1'b1; DA = 5'd1; K = 64'd5;
    exp_q.push_back(64'd0);
    tick();
    e = exp_q.pop_front(); vectors++;
    if (r1 !== e[15:0]) begin
      miscompares++; $display("FAIL write_in_reset got %h expected %h", r1, e[15:0]);
    end
    idle_inputs();
    RST = 1'b1;
  endtask

  task automatic test_load();
    logic [63:0] e;
    SA = 5'd30; SB = 5'd30; M = 1'b0; FS = 5'b01000; EN_ALU = 1'b1; WR = 1'b1; C0 = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      K = 64'(i); DA = 5'(i);
      exp_q.push_back(64'(i));
      tick();
    end
    WR = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      e = exp_q.pop_front(); vectors++;
      if (rv[i] !== e[15:0]) begin
        miscompares++; $display("FAIL load_r%0d got %h expected %h", i, rv[i], e[15:0]);
      end
    end
  endtask

  task automatic test_arith();
    logic [63:0] e;
    M = 1'b1; SA = 5'd1; SB = 5'd7; FS = 5'b01000; C0 = 1'b0; DA = 5'd0; WR = 1'b1; EN_ALU = 1'b1;
    exp_q.push_back(64'b0000);
    exp_q.push_back(64'd8);
    #1;
    e = exp_q.pop_front(); vectors++;
    if (STAT !== e[3:0]) begin
      miscompares++; $display("FAIL add_stat got %b expected %b", STAT, e[3:0]);
    end
    tick();
    e = exp_q.pop_front(); vectors++;
    if (r0 !== e[15:0]) begin
      miscompares++; $display("FAIL add_r0 got %h expected %h", r0, e[15:0]);
    end
    SA = 5'd0; SB = 5'd5; FS = 5'b01001; C0 = 1'b1; DA = 5'd1;
    exp_q.push_back(64'b0100);
    exp_q.push_back(64'd3);
    #1;
    e = exp_q.pop_front(); vectors++;
    if (STAT !== e[3:0]) begin
      miscompares++; $display("FAIL sub_stat got %b expected %b", STAT, e[3:0]);
    end
    tick();
    e = exp_q.pop_front(); vectors++;
    if (r1 !== e[15:0]) begin
      miscompares++; $display("FAIL sub_r1 got %h expected %h", r1, e[15:0]);
    end
    idle_inputs();
  endtask

  task automatic test_ram();
    logic [63:0] e;
    M = 1'b0; K = 64'd0; SA = 5'd2; FS = 5'b00100; EN_ADDR_ALU = 1'b1; EN_B = 1'b1; SB = 5'd7;
    RCS = 1'b1; RWE = 1'b1; WR = 1'b0;
    tick();
    ROE = 1'b1; RWE = 1'b0; WR = 1'b1; DA = 5'd7;
    exp_q.push_back(64'd7);
    tick();
    e = exp_q.pop_front(); vectors++;
    if (r7 !== e[15:0]) begin
      miscompares++; $display("FAIL ram_rd_r7 got %h expected %h", r7, e[15:0]);
    end
    // RAM read wins over an enabled ALU result (which would be 2)
    EN_ALU = 1'b1; DA = 5'd6;
    exp_q.push_back(64'd7);
    tick();
    e = exp_q.pop_front(); vectors++;
    if (r6 !== e[15:0]) begin
      miscompares++; $display("FAIL ram_prio_r6 got %h expected %h", r6, e[15:0]);
    end
    idle_inputs();
  endtask

  task automatic test_move();
    logic [63:0] e;
    EN_ALU = 1'b0; EN_B = 1'b1; DA = 5'd3; SB = 5'd2; WR = 1'b1;
    exp_q.push_back(64'd2);
    tick();
    e = exp_q.pop_front(); vectors++;
    if (r3 !== e[15:0]) begin
      miscompares++; $display("FAIL move_r3 got %h expected %h", r3, e[15:0]);
    end
    DA = 5'd31; SB = 5'd5;
    tick();
    DA = 5'd4; SB = 5'd31;
    exp_q.push_back(64'd0);
    tick();
    e = exp_q.pop_front(); vectors++;
    if (r4 !== e[15:0]) begin
      miscompares++; $display("FAIL r31_zero got %h expected %h", r4, e[15:0]);
    end
    idle_inputs();
  endtask

  task automatic test_overflow();
    logic [63:0] e;
    SA = 5'd30; M = 1'b0; K = 64'h7FFF_FFFF_FFFF_FFFF; FS = 5'b00100; EN_ALU = 1'b1; WR = 1'b1; DA = 5'd8;
    tick();
    K = 64'hFFFF_FFFF_FFFF_FFFF; DA = 5'd9;
    tick();
    WR = 1'b0; SA = 5'd8; K = 64'd1; FS = 5'b01000; C0 = 1'b0;
    exp_q.push_back(64'b1010);
    #1;
    e = exp_q.pop_front(); vectors++;
    if (STAT !== e[3:0]) begin
      miscompares++; $display("FAIL ovf_stat got %b expected %b", STAT, e[3:0]);
    end
    SA = 5'd9;
    exp_q.push_back(64'b0101);
    #1;
    e = exp_q.pop_front(); vectors++;
    if (STAT !== e[3:0]) begin
      miscompares++; $display("FAIL carry_wrap_stat got %b expected %b", STAT, e[3:0]);
    end
    idle_inputs();
  endtask

  task automatic test_shift();
    logic [63:0] e;
    SA = 5'd2; M = 1'b0; K = 64'd3; FS = 5'b10000;
`ifdef DATAPATH_SHIFT_EN
    exp_q.push_back(64'b0000);
`else
    exp_q.push_back(64'b0001);
`endif
    #1;
    e = exp_q.pop_front(); vectors++;
    if (STAT !== e[3:0]) begin
      miscompares++; $display("FAIL shl_stat got %b expected %b", STAT, e[3:0]);
    end
    K = 64'd1; FS = 5'b11000;
    exp_q.push_back(64'b0001);
    #1;
    e = exp_q.pop_front(); vectors++;
    if (STAT !== e[3:0]) begin
      miscompares++; $display("FAIL fn_zero_stat got %b expected %b", STAT, e[3:0]);
    end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    logic [63:0] e, res, bus;
    logic [3:0]  st;
    logic [7:0]  addr;
    // same-cycle read of DA sees old value; next cycle sees new one
    SA = 5'd5; DA = 5'd5; M = 1'b0; K = 64'd1; FS = 5'b01000; EN_ALU = 1'b1; WR = 1'b1;
    exp_q.push_back(64'd6);
    exp_q.push_back(64'd7);
    tick();
    e = exp_q.pop_front(); vectors++;
    if (r5 !== e[15:0]) begin
      miscompares++; $display("FAIL rbw_first got %h expected %h", r5, e[15:0]);
    end
    tick();
    e = exp_q.pop_front(); vectors++;
    if (r5 !== e[15:0]) begin
      miscompares++; $display("FAIL rbw_second got %h expected %h", r5, e[15:0]);
    end
    for (int n = 0; n < 60; n++) begin
      SA = 5'($urandom_range(0, 31)); SB = 5'($urandom_range(0, 31));
      DA = 5'($urandom_range(0, 31)); FS = 5'($urandom_range(0, 31));
      K = {$urandom, $urandom}; M = 1'($urandom); C0 = 1'($urandom);
      EN_ALU = 1'($urandom); EN_B = 1'($urandom); WR = ($urandom_range(0, 3) != 0);
      if (n % 9 == 0) K = 64'd0;
      eval(res, st, bus, addr);
      exp_q.push_back({60'd0, st});
      #1;
      e = exp_q.pop_front(); vectors++;
      if (STAT !== e[3:0]) begin
        miscompares++; $display("FAIL rand_stat n=%0d fs=%b got %b expected %b", n, FS, STAT, e[3:0]);
      end
      tick();
      for (int i = 0; i < 8; i++) exp_q.push_back({48'd0, mreg[i][15:0]});
      for (int i = 0; i < 8; i++) begin
        e = exp_q.pop_front(); vectors++;
        if (rv[i] !== e[15:0]) begin
          miscompares++; $display("FAIL rand_r%0d n=%0d got %h expected %h", i, n, rv[i], e[15:0]);
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_async_reset();
    logic [63:0] e;
    SA = 5'd30; M = 1'b0; K = 64'h1234; FS = 5'b01000; EN_ALU = 1'b1; WR = 1'b1; DA = 5'd2;
    tick();
    #2;
    RST = 1'b0;
    for (int i = 0; i < 32; i++) mreg[i] = 64'd0;
    for (int i = 0; i < 8; i++) exp_q.push_back(64'd0);
    #1;
    for (int i = 0; i < 8; i++) begin
      e = exp_q.pop_front(); vectors++;
      if (rv[i] !== e[15:0]) begin
        miscompares++; $display("FAIL async_rst_r%0d got %h expected %h", i, rv[i], e[15:0]);
      end
    end
    tick();
    RST = 1'b1; K = 64'd9;
    exp_q.push_back(64'd9);
    tick();
    e = exp_q.pop_front(); vectors++;
    if (r2 !== e[15:0]) begin
      miscompares++; $display("FAIL post_rst_write got %h expected %h", r2, e[15:0]);
    end
    idle_inputs();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mreg[i] = 64'd0;
    idle_inputs();
    RST = 1'b0;
    @(posedge CLK);
    #1;
    test_reset();
    test_load();
    test_arith();
    test_ram();
    test_move();
    test_overflow();
    test_shift();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
